// File: rtl/sram_wb_responder.sv
// sram_wb_responder: Wishbone B4 classic slave driving a 1RW OpenRAM-style macro port.
module sram_wb_responder #(
  parameter int ADDR_W       = 10,
  parameter int RAM_ADDR_W   = 8,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [ADDR_W-1:0]     wb_addr_i,
  input  logic [31:0]           wb_dat_i,
  output logic                  wb_ack_o,
  output logic [31:0]           wb_dat_o,
  output logic                  ram_csb0,
  output logic                  ram_web0,
  output logic [3:0]            ram_wmask0,
  output logic [RAM_ADDR_W-1:0] ram_addr0,
  output logic [31:0]           ram_din0,
  input  logic [31:0]           ram_dout0
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;
  state_t                state_q, state_d;
  logic                  ack_q, ack_d, csb_q, csb_d, web_q, web_d;
  logic [31:0]           dat_q, dat_d, din_q, din_d;
  logic [3:0]            wmask_q, wmask_d;
  logic [RAM_ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  req, oor;
  assign req = wb_stb_i & wb_cyc_i;
  assign oor = {1'b0, wb_addr_i} >= (ADDR_W+1)'(DEPTH);
  // web_q stays low only during ACCESS of a write, so it doubles as the write flag there
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    csb_d   = 1'b1;
    web_d   = 1'b1;
    wmask_d = '0;
    addr_d  = addr_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req) begin
        if (oor || (wb_we_i && wb_sel_i == 4'h0)) begin
          state_d = ACK;
          ack_d   = 1'b1;
          dat_d   = (oor && !wb_we_i) ? '0 : dat_q;
        end else begin
          state_d = ACCESS;
          csb_d   = 1'b0;
          web_d   = ~wb_we_i;
          wmask_d = wb_we_i ? wb_sel_i : 4'h0;
          addr_d  = wb_addr_i[RAM_ADDR_W-1:0];
          din_d   = wb_dat_i;
        end
      end
      ACCESS: begin
        state_d = !wb_cyc_i ? IDLE : (!web_q ? ACK : WAIT);
        ack_d   = wb_cyc_i && !web_q;
        cnt_d   = 3'(READ_LATENCY - 1);
      end
      WAIT: if (!wb_cyc_i) state_d = IDLE;
      else if (cnt_q == 3'd0) begin
        state_d = ACK;
        ack_d   = 1'b1;
        dat_d   = ram_dout0;
      end else cnt_d = cnt_q - 3'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
    end
  end
  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign ram_csb0   = csb_q;
  assign ram_web0   = web_q;
  assign ram_wmask0 = wmask_q;
  assign ram_addr0  = addr_q;
  assign ram_din0   = din_q;
endmodule

// File: tb/tb_sram_wb_responder.sv
// tb_sram_wb_responder: directed checks of two responders (read latency 1 and 3) sharing one Wishbone stimulus.
module tb_sram_wb_responder;
  logic        clk = 1'b0, reset, stb, cyc, we;
  logic [3:0]  sel;
  logic [9:0]  addr;
  logic [31:0] dat;
  logic        ack1, csb1, web1, ack3, csb3, web3;
  logic [31:0] dat1, din1, dout1, dat3, din3, dout3;
  logic [3:0]  wm1, wm3;
  logic [7:0]  ra1, ra3;
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] p3_0, p3_1, p3_2;
  int errs = 0, checks = 0;
  int lat1, lat3, csbn1, csbn3, ackn1, ackn3;
  logic [3:0] wmseen1;
  always #5 clk = ~clk;
  sram_wb_responder #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_we_i(we), .wb_sel_i(sel),
    .wb_addr_i(addr), .wb_dat_i(dat), .wb_ack_o(ack1), .wb_dat_o(dat1), .ram_csb0(csb1),
    .ram_web0(web1), .ram_wmask0(wm1), .ram_addr0(ra1), .ram_din0(din1), .ram_dout0(dout1));
  sram_wb_responder #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_we_i(we), .wb_sel_i(sel),
    .wb_addr_i(addr), .wb_dat_i(dat), .wb_ack_o(ack3), .wb_dat_o(dat3), .ram_csb0(csb3),
    .ram_web0(web3), .ram_wmask0(wm3), .ram_addr0(ra3), .ram_din0(din3), .ram_dout0(dout3));
  // Macro models: data valid READ_LATENCY cycles after the edge that samples csb0 low
  always @(posedge clk) begin
    if (!csb1 && !web1) begin
      for (int b = 0; b < 4; b++) if (wm1[b]) mem1[ra1][8*b +: 8] <= din1[8*b +: 8];
    end
    if (!csb1 && web1) dout1 <= mem1[ra1];
  end
  always @(posedge clk) begin
    if (!csb3 && !web3) begin
      for (int b = 0; b < 4; b++) if (wm3[b]) mem3[ra3][8*b +: 8] <= din3[8*b +: 8];
    end
    if (!csb3 && web3) p3_0 <= mem3[ra3];
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign dout3 = p3_2;

  task automatic txn(input logic w, input logic [9:0] a, input logic [3:0] s, input logic [31:0] d);
    we = w; addr = a; sel = s; dat = d; stb = 1'b1; cyc = 1'b1;
    lat1 = -1; lat3 = -1; csbn1 = 0; csbn3 = 0; ackn1 = 0; ackn3 = 0; wmseen1 = 4'h0;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk); #1;
      stb = 1'b0;
      if (ack1) begin ackn1++; if (lat1 < 0) lat1 = j; end
      if (ack3) begin ackn3++; if (lat3 < 0) lat3 = j; end
      if (!csb1) begin csbn1++; wmseen1 = wm1; end
      if (!csb3) csbn3++;
    end
    cyc = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    checks++; if (ack1 !== 1'b0 || ack3 !== 1'b0) begin errs++; $display("FAIL rst_ack got %b/%b want 0", ack1, ack3); end
    checks++; if (dat1 !== 32'h0 || dat3 !== 32'h0) begin errs++; $display("FAIL rst_dat got %h/%h want 0", dat1, dat3); end
    checks++; if ({csb1, web1, wm1} !== 6'b110000) begin errs++; $display("FAIL rst_ram got csb=%b web=%b wm=%h want 1 1 0", csb1, web1, wm1); end
    checks++; if (ra1 !== 8'h0 || din1 !== 32'h0) begin errs++; $display("FAIL rst_addr_din got %h %h want 0 0", ra1, din1); end
  endtask

  task automatic test_write_read;
    txn(1'b1, 10'h010, 4'hF, 32'hDEADBEEF);
    checks++; if (lat1 !== 1) begin errs++; $display("FAIL wr_lat got %0d want 1", lat1); end
    checks++; if (csbn1 !== 1) begin errs++; $display("FAIL wr_csb_cycles got %0d want 1", csbn1); end
    checks++; if (wmseen1 !== 4'hF) begin errs++; $display("FAIL wr_wmask got %h want f", wmseen1); end
    checks++; if (ackn1 !== 1) begin errs++; $display("FAIL wr_ack_count got %0d want 1", ackn1); end
    txn(1'b0, 10'h010, 4'hF, 32'h0);
    checks++; if (lat1 !== 2) begin errs++; $display("FAIL rd_lat1 got %0d want 2", lat1); end
    checks++; if (dat1 !== 32'hDEADBEEF) begin errs++; $display("FAIL rd_dat1 got %h want deadbeef", dat1); end
    checks++; if (lat3 !== 4) begin errs++; $display("FAIL rd_lat3 got %0d want 4", lat3); end
    checks++; if (dat3 !== 32'hDEADBEEF) begin errs++; $display("FAIL rd_dat3 got %h want deadbeef", dat3); end
    checks++; if (wmseen1 !== 4'h0) begin errs++; $display("FAIL rd_wmask got %h want 0", wmseen1); end
  endtask

  task automatic test_byte_write;
    txn(1'b1, 10'h010, 4'b0010, 32'h0000AB00);
    checks++; if (wmseen1 !== 4'b0010) begin errs++; $display("FAIL bw_wmask got %h want 2", wmseen1); end
    checks++; if (dat1 !== 32'hDEADBEEF) begin errs++; $display("FAIL bw_dat_hold got %h want deadbeef", dat1); end
    txn(1'b0, 10'h010, 4'h0, 32'h0);
    checks++; if (dat1 !== 32'hDEADABEF) begin errs++; $display("FAIL bw_rd1 got %h want deadabef", dat1); end
    checks++; if (dat3 !== 32'hDEADABEF) begin errs++; $display("FAIL bw_rd3 got %h want deadabef", dat3); end
    checks++; if (lat3 !== 4) begin errs++; $display("FAIL bw_lat3 got %0d want 4", lat3); end
  endtask

  task automatic test_out_of_range;
    txn(1'b0, 10'h100, 4'hF, 32'h0);
    checks++; if (lat1 !== 0) begin errs++; $display("FAIL oor_rd_lat got %0d want 0", lat1); end
    checks++; if (dat1 !== 32'h0) begin errs++; $display("FAIL oor_rd_dat got %h want 0", dat1); end
    checks++; if (csbn1 !== 0) begin errs++; $display("FAIL oor_rd_csb got %0d want 0", csbn1); end
    txn(1'b1, 10'h0FF, 4'hF, 32'h11111111);
    txn(1'b1, 10'h3FF, 4'hF, 32'h22222222);
    checks++; if (lat1 !== 0 || csbn1 !== 0) begin errs++; $display("FAIL oor_wr got lat=%0d csb=%0d want 0 0", lat1, csbn1); end
    txn(1'b1, 10'h0FF, 4'h0, 32'h33333333);
    checks++; if (lat1 !== 0 || csbn1 !== 0) begin errs++; $display("FAIL sel0_wr got lat=%0d csb=%0d want 0 0", lat1, csbn1); end
    txn(1'b0, 10'h0FF, 4'hF, 32'h0);
    checks++; if (dat1 !== 32'h11111111) begin errs++; $display("FAIL oor_alias got %h want 11111111", dat1); end
  endtask

  task automatic test_back_to_back;
    int acks, acc, last_ack, gap_bad, dat_bad, addr_bad, extra;
    for (int i = 0; i < 8; i++) txn(1'b1, 10'(10'h40 + i), 4'hF, 32'hA5000000 + 32'(i));
    acks = 0; acc = 0; last_ack = 0; gap_bad = 0; dat_bad = 0; addr_bad = 0; extra = 0;
    we = 1'b0; sel = 4'hF; addr = 10'h40; stb = 1'b1; cyc = 1'b1;
    for (int e = 0; e < 100 && acks < 8; e++) begin
      @(posedge clk); #1;
      if (!csb1) begin
        acc++;
        if (acks > 0 && e - last_ack != 2) gap_bad++;
        if (ra1 !== 8'(64 + acks)) addr_bad++;
      end
      if (ack1) begin
        if (dat1 !== 32'hA5000000 + 32'(acks)) dat_bad++;
        acks++; last_ack = e; addr = 10'(10'h40 + acks);
      end
    end
    stb = 1'b0; cyc = 1'b0;
    for (int e = 0; e < 6; e++) begin @(posedge clk); #1; if (ack1 || !csb1) extra++; end
    checks++; if (acks !== 8) begin errs++; $display("FAIL b2b_acks got %0d want 8", acks); end
    checks++; if (acc !== 8) begin errs++; $display("FAIL b2b_accesses got %0d want 8", acc); end
    checks++; if (gap_bad !== 0) begin errs++; $display("FAIL b2b_gap got %0d bad gaps want 0", gap_bad); end
    checks++; if (dat_bad !== 0) begin errs++; $display("FAIL b2b_data got %0d bad words want 0", dat_bad); end
    checks++; if (addr_bad !== 0) begin errs++; $display("FAIL b2b_addr got %0d bad addrs want 0", addr_bad); end
    checks++; if (extra !== 0) begin errs++; $display("FAIL b2b_extra got %0d want 0", extra); end
  endtask

  task automatic test_abort;
    int n;
    txn(1'b0, 10'h100, 4'hF, 32'h0);
    checks++; if (dat3 !== 32'h0) begin errs++; $display("FAIL abort_pre got %h want 0", dat3); end
    n = 0; we = 1'b0; addr = 10'h010; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    for (int j = 0; j < 9; j++) begin
      @(posedge clk); #1;
      stb = 1'b0;
      if (ack3) n++;
      if (j == 2) cyc = 1'b0;
    end
    checks++; if (n !== 0) begin errs++; $display("FAIL abort_ack got %0d want 0", n); end
    checks++; if (dat3 !== 32'h0) begin errs++; $display("FAIL abort_dat got %h want 0", dat3); end
    txn(1'b0, 10'h010, 4'hF, 32'h0);
    checks++; if (lat3 !== 4 || dat3 !== 32'hDEADABEF) begin errs++; $display("FAIL abort_next got lat=%0d dat=%h want 4 deadabef", lat3, dat3); end
  endtask

  task automatic test_reset_mid;
    we = 1'b1; addr = 10'h050; sel = 4'hF; dat = 32'h5A5A5A5A; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); #1;
    checks++; if (csb1 !== 1'b0) begin errs++; $display("FAIL rm_access got csb=%b want 0", csb1); end
    reset = 1'b1; #1;
    checks++; if (csb1 !== 1'b1 || ack1 !== 1'b0) begin errs++; $display("FAIL rm_ctl got csb=%b ack=%b want 1 0", csb1, ack1); end
    checks++; if (dat1 !== 32'h0) begin errs++; $display("FAIL rm_dat got %h want 0", dat1); end
    stb = 1'b0; cyc = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    txn(1'b0, 10'h0FF, 4'hF, 32'h0);
    checks++; if (lat1 !== 2 || dat1 !== 32'h11111111) begin errs++; $display("FAIL rm_after got lat=%0d dat=%h want 2 11111111", lat1, dat1); end
  endtask

  initial begin
    reset = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; addr = '0; dat = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_write_read();
    test_byte_write();
    test_out_of_range();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
